// File: rtl/vmicro16_apb_arbiter_if.sv
// Bus bundle between the per-core APB masters, the arbiter and the shared peripheral bus.
// The arbiter connects through the slave modport; the cores/peripheral side uses master.
interface vmicro16_apb_arbiter_if #(
  parameter int MASTER_PORTS = 4,
  parameter int SLAVE_PORTS  = 5,
  parameter int BUS_WIDTH    = 16
);
  localparam int GID_W = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;

  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR;
  logic [MASTER_PORTS-1:0]           S_PWRITE;
  logic [MASTER_PORTS-1:0]           S_PSELx;
  logic [MASTER_PORTS-1:0]           S_PENABLE;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA;
  logic [MASTER_PORTS-1:0]           S_PREADY;

  logic [BUS_WIDTH-1:0]              M_PADDR;
  logic                              M_PWRITE;
  logic [SLAVE_PORTS-1:0]            M_PSELx;
  logic                              M_PENABLE;
  logic [BUS_WIDTH-1:0]              M_PWDATA;
  logic [BUS_WIDTH-1:0]              M_PRDATA;
  logic                              M_PREADY;

  logic [GID_W-1:0]                  grant_id;
  logic                              bus_err;

  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
    output S_PRDATA, S_PREADY, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
           grant_id, bus_err
  );

  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
    input  S_PRDATA, S_PREADY, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
           grant_id, bus_err
  );
endinterface

// File: rtl/vmicro16_apb_arbiter.sv
// Round-robin APB arbiter and address decoder: one core master owns the shared peripheral
// bus at a time; decode errors and hung slaves are terminated with ERR_DATA.
module vmicro16_apb_arbiter #(
  parameter int                   MASTER_PORTS = 4,
  parameter int                   SLAVE_PORTS  = 5,
  parameter int                   BUS_WIDTH    = 16,
  parameter int                   SEL_LSB      = 8,
  parameter int                   TIMEOUT      = 255,
  parameter logic [BUS_WIDTH-1:0] ERR_DATA     = 16'hDEAD
) (
  input logic                  clk,
  input logic                  reset,
  vmicro16_apb_arbiter_if.slave bus
);
  localparam int GID_W = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_e;

  state_e               state_q, state_d;
  logic [GID_W-1:0]     grant_q, grant_d;
  logic [GID_W-1:0]     last_q, last_d;
  logic [BUS_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                 pwrite_q, pwrite_d;
  logic [3:0]           sel_q, sel_d;
  logic [7:0]           cnt_q, cnt_d;

  logic [BUS_WIDTH-1:0] s_paddr  [MASTER_PORTS];
  logic [BUS_WIDTH-1:0] s_pwdata [MASTER_PORTS];
  logic                 req_found;
  logic [GID_W-1:0]     req_pick;
  logic [GID_W-1:0]     cand;
  logic [3:0]           req_sel;
  logic                 timeout_hit;
  logic                 resp_valid;
  logic [BUS_WIDTH-1:0] resp_data;
  logic [SLAVE_PORTS-1:0] sel_onehot;

  // Enable is part of the APB protocol but carries no arbitration information.
  logic unused_penable;
  assign unused_penable = &{1'b0, bus.S_PENABLE};

  for (genvar g = 0; g < MASTER_PORTS; g++) begin : g_lane
    assign s_paddr[g]  = bus.S_PADDR[BUS_WIDTH*g +: BUS_WIDTH];
    assign s_pwdata[g] = bus.S_PWDATA[BUS_WIDTH*g +: BUS_WIDTH];
  end

  // Search starts one past the last completed master so every requester gets a turn.
  always_comb begin : rr_search
    // NOTE: every variable written in a combinational block gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    req_found = 1'b0;
    req_pick  = last_q;
    cand      = '0;
    for (int i = 1; i <= MASTER_PORTS; i++) begin
      cand = GID_W'((int'(last_q) + i) % MASTER_PORTS);
      if (!req_found && bus.S_PSELx[cand]) begin
        req_found = 1'b1;
        req_pick  = cand;
      end
    end
  end

  assign req_sel     = s_paddr[req_pick][SEL_LSB+3:SEL_LSB];
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin : next_state
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_found) begin
          grant_d  = req_pick;
          paddr_d  = s_paddr[req_pick];
          pwdata_d = s_pwdata[req_pick];
          pwrite_d = bus.S_PWRITE[req_pick];
          sel_d    = req_sel;
          state_d  = (int'(req_sel) < SLAVE_PORTS) ? SETUP : ERR;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.M_PREADY || timeout_hit) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ERR: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    sel_onehot = '0;
    for (int s = 0; s < SLAVE_PORTS; s++) sel_onehot[s] = (int'(sel_q) == s);

    bus.M_PSELx   = '0;
    bus.M_PENABLE = 1'b0;
    bus.bus_err   = 1'b0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    unique case (state_q)
      SETUP: bus.M_PSELx = sel_onehot;
      ACCESS: begin
        bus.M_PSELx   = sel_onehot;
        bus.M_PENABLE = 1'b1;
        resp_valid    = bus.M_PREADY || timeout_hit;
        resp_data     = bus.M_PREADY ? bus.M_PRDATA : ERR_DATA;
        bus.bus_err   = !bus.M_PREADY && timeout_hit;
      end
      ERR: begin
        resp_valid  = 1'b1;
        resp_data   = ERR_DATA;
        bus.bus_err = 1'b1;
      end
      default: ;
    endcase

    bus.S_PREADY = '0;
    bus.S_PRDATA = '0;
    for (int i = 0; i < MASTER_PORTS; i++) begin
      if (resp_valid && int'(grant_q) == i) begin
        bus.S_PREADY[i] = 1'b1;
        bus.S_PRDATA[BUS_WIDTH*i +: BUS_WIDTH] = resp_data;
      end
    end
  end

  assign bus.M_PADDR  = paddr_q;
  assign bus.M_PWRITE = pwrite_q;
  assign bus.M_PWDATA = pwdata_q;
  assign bus.grant_id = grant_q;

  // NOTE: every flop here is reset so an aborted transfer leaves no stale bus state behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= GID_W'(MASTER_PORTS - 1);
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_vmicro16_apb_arbiter.sv
// Self-checking bench for vmicro16_apb_arbiter: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a transaction-timeline model.
module tb_vmicro16_apb_arbiter;
  localparam int          MP   = 4;
  localparam int          SP   = 5;
  localparam int          BW   = 16;
  localparam int          TMO  = 4;
  localparam logic [15:0] ERRD = 16'hDEAD;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vmicro16_apb_arbiter_if #(.MASTER_PORTS(MP), .SLAVE_PORTS(SP), .BUS_WIDTH(BW)) bus ();

  vmicro16_apb_arbiter #(
    .MASTER_PORTS(MP), .SLAVE_PORTS(SP), .BUS_WIDTH(BW), .SEL_LSB(8),
    .TIMEOUT(TMO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Peripheral model: raises M_PREADY on ACCESS cycle slv_wait+1 (never if slv_wait < 0).
  int          slv_wait = 0;
  logic [15:0] slv_rdata = '0;
  int          acc_n = 0;
  initial begin
    bus.M_PREADY = 1'b0;
    bus.M_PRDATA = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.M_PENABLE) begin
        acc_n++;
        bus.M_PREADY = (slv_wait >= 0) && (acc_n == slv_wait + 1);
      end else begin
        acc_n = 0;
        bus.M_PREADY = 1'b0;
      end
      bus.M_PRDATA = bus.M_PREADY ? slv_rdata : 16'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic [15:0] a, input logic w,
                       input logic [15:0] d, input logic sel);
    bus.S_PADDR[16*m +: 16]  = a;
    bus.S_PWDATA[16*m +: 16] = d;
    bus.S_PWRITE[m]          = w;
    bus.S_PSELx[m]           = sel;
    bus.S_PENABLE[m]         = sel;
  endtask

  task automatic drop_all();
    bus.S_PSELx   = '0;
    bus.S_PENABLE = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [63:0] lane(input int m, input logic [15:0] d);
    return 64'(d) << (16 * m);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"}, 64'(bus.M_PSELx), 0);
    check({tag, "_pen"}, 64'(bus.M_PENABLE), 0);
    check({tag, "_maddr"}, {bus.M_PADDR, bus.M_PWDATA, 15'd0, bus.M_PWRITE}, 0);
    check({tag, "_pready"}, 64'(bus.S_PREADY), 0);
    check({tag, "_prdata"}, bus.S_PRDATA, 0);
    check({tag, "_err_gid"}, {bus.bus_err, bus.grant_id}, 0);
  endtask

  typedef struct {
    int          m;
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    int          wait_n;
    logic [15:0] rdata;
    logic [4:0]  exp_sel;
    int          exp_resp;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    tick();
    drop_all();
    drive(v.m, v.addr, v.wr, v.wdata, 1'b1);
    slv_wait  = v.wait_n;
    slv_rdata = v.rdata;
    for (int c = 1; c <= v.exp_resp; c++) begin
      @(negedge clk);
      check("vec_psel", 64'(bus.M_PSELx), (c >= 2) ? 64'(v.exp_sel) : 64'd0);
      check("vec_pen", 64'(bus.M_PENABLE), 64'((v.exp_sel != 0) && (c >= 3)));
      if (c == 2)
        check("vec_latch", {bus.M_PADDR, bus.M_PWDATA, 15'd0, bus.M_PWRITE},
              {v.addr, v.wdata, 15'd0, v.wr});
      if (c == v.exp_resp) begin
        check("vec_pready", 64'(bus.S_PREADY), 64'(1) << v.m);
        check("vec_prdata", bus.S_PRDATA, lane(v.m, v.exp_data));
        check("vec_err_gid", {bus.bus_err, bus.grant_id}, {v.exp_err, 2'(v.m)});
      end else begin
        check("vec_wait", {bus.bus_err, bus.S_PREADY}, 0);
      end
    end
    tick();
    drop_all();
    @(negedge clk);
    check("vec_idle", {bus.M_PSELx, bus.S_PREADY}, 0);
  endtask

  // Transaction-timeline reference model for random traffic.
  bit          m_busy;
  int          m_cur, m_start, m_resp, m_last, m_idx;
  logic [15:0] m_addr, m_wdata, m_rdata;
  logic        m_wr, m_ok, m_bad;
  bit          active [MP];
  bit          done   [MP];
  int          gap    [MP];
  logic [15:0] r_addr [MP];
  logic [15:0] r_wdata[MP];
  logic        r_wr   [MP];

  task automatic model_step(input int n);
    int w;
    bit found;
    if (m_busy) begin
      check("rnd_psel", 64'(bus.M_PSELx), m_ok ? (64'(1) << m_idx) : 64'd0);
      check("rnd_pen", 64'(bus.M_PENABLE), 64'(m_ok && n >= m_start + 2));
      check("rnd_gid", 64'(bus.grant_id), 64'(m_cur));
      check("rnd_latch", {bus.M_PADDR, bus.M_PWDATA, 15'd0, bus.M_PWRITE},
            {m_addr, m_wdata, 15'd0, m_wr});
      if (n == m_resp) begin
        check("rnd_pready", 64'(bus.S_PREADY), 64'(1) << m_cur);
        check("rnd_prdata", bus.S_PRDATA, lane(m_cur, m_bad ? ERRD : m_rdata));
        check("rnd_err", 64'(bus.bus_err), 64'(m_bad));
        m_busy      = 1'b0;
        m_last      = m_cur;
        done[m_cur] = 1'b1;
      end else begin
        check("rnd_wait", {bus.bus_err, bus.S_PREADY}, 0);
        check("rnd_wait_data", bus.S_PRDATA, 0);
      end
    end else begin
      check("rnd_idle", {bus.bus_err, bus.M_PENABLE, bus.M_PSELx, bus.S_PREADY}, 0);
      found = 1'b0;
      for (int k = 1; k <= MP; k++) begin
        int c;
        c = (m_last + k) % MP;
        if (!found && bus.S_PSELx[c]) begin
          found = 1'b1;
          m_cur = c;
        end
      end
      if (found) begin
        m_addr    = r_addr[m_cur];
        m_wdata   = r_wdata[m_cur];
        m_wr      = r_wr[m_cur];
        m_idx     = int'(m_addr[11:8]);
        m_ok      = m_idx < SP;
        w         = int'($urandom_range(0, 5));
        m_bad     = !m_ok || (w + 1 > TMO);
        m_start   = n;
        m_resp    = n + 1 + (m_ok ? ((w + 1 < TMO) ? w + 1 : TMO) : 0);
        m_rdata   = 16'($urandom);
        slv_wait  = w;
        slv_rdata = m_rdata;
        m_busy    = 1'b1;
      end
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 16'h0402, 1'b0, 16'h0000,  0, 16'h1234, 5'b10000, 3, 16'h1234, 1'b0};
    vecs[1] = '{2, 16'h0100, 1'b1, 16'hBEEF,  0, 16'h0000, 5'b00010, 3, 16'h0000, 1'b0};
    vecs[2] = '{3, 16'h0900, 1'b0, 16'h0000,  0, 16'h0000, 5'b00000, 2, ERRD,     1'b1};
    vecs[3] = '{1, 16'h0300, 1'b0, 16'h0000, -1, 16'h0000, 5'b01000, 6, ERRD,     1'b1};
    vecs[4] = '{1, 16'h0300, 1'b0, 16'h0000,  3, 16'h5555, 5'b01000, 6, 16'h5555, 1'b0};
    vecs[5] = '{0, 16'h0000, 1'b1, 16'h0A0A,  1, 16'h00C3, 5'b00001, 4, 16'h00C3, 1'b0};
    vecs[6] = '{3, 16'h0F42, 1'b1, 16'h7777,  0, 16'h0000, 5'b00000, 2, ERRD,     1'b1};

    reset = 1'b0;
    bus.S_PADDR = '0; bus.S_PWDATA = '0; bus.S_PWRITE = '0;
    drop_all();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // All four masters hold requests: grants rotate 0,1,2,3,0 with one IDLE between.
    do_reset();
    tick();
    slv_wait = 0;
    slv_rdata = 16'hA5A5;
    for (int i = 0; i < MP; i++) drive(i, 16'(i << 8), 1'b0, 16'h0, 1'b1);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        check("rr_pready", 64'(bus.S_PREADY), 64'(1) << ((c / 3 - 1) % MP));
        check("rr_gid", 64'(bus.grant_id), 64'((c / 3 - 1) % MP));
        check("rr_psel", 64'(bus.M_PSELx), 64'(1) << ((c / 3 - 1) % MP));
      end else begin
        check("rr_wait", 64'(bus.S_PREADY), 0);
        if (c % 3 == 1) check("rr_idle", {bus.M_PENABLE, bus.M_PSELx}, 0);
      end
    end
    tick();
    drop_all();

    // A master that withdraws before grant is skipped; post-grant address changes ignored.
    do_reset();
    tick();
    drive(0, 16'h0000, 1'b0, 16'h1111, 1'b1);
    drive(2, 16'h0200, 1'b0, 16'h2222, 1'b1);
    tick();
    drive(2, 16'h0200, 1'b0, 16'h2222, 1'b0);
    drive(3, 16'h0300, 1'b1, 16'h3333, 1'b1);
    drive(0, 16'h0400, 1'b1, 16'hFFFF, 1'b1);
    @(negedge clk);
    check("skip_latch", {bus.M_PADDR, bus.M_PWDATA}, {16'h0000, 16'h1111});
    tick();
    @(negedge clk);
    check("skip_m0_done", 64'(bus.S_PREADY), 64'b0001);
    tick();
    drive(0, 16'h0400, 1'b1, 16'hFFFF, 1'b0);
    tick();
    @(negedge clk);
    check("skip_grant3", {bus.grant_id, bus.M_PSELx, bus.M_PADDR},
          {2'd3, 5'b01000, 16'h0300});
    tick();
    @(negedge clk);
    check("skip_m3_done", 64'(bus.S_PREADY), 64'b1000);
    tick();
    drop_all();

    // Reset in the middle of ACCESS: outputs clear at once, pointer restarts at master 0.
    do_reset();
    tick();
    slv_wait = 0;
    drive(0, 16'h0000, 1'b0, 16'h0, 1'b1);
    tick(); tick(); tick();
    slv_wait = -1;
    drive(1, 16'h0100, 1'b0, 16'h0, 1'b1);
    tick(); tick(); tick();
    @(negedge clk);
    check("rst_pre", {bus.M_PENABLE, bus.grant_id}, {1'b1, 2'd1});
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    slv_wait = 0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_regrant", {bus.grant_id, bus.M_PSELx, bus.S_PREADY}, {2'd0, 5'b00001, 4'b0});
    @(negedge clk);
    check("rst_done", 64'(bus.S_PREADY), 64'b0001);
    tick();
    drop_all();

    // Random traffic against the timeline model.
    do_reset();
    m_busy = 1'b0;
    m_last = MP - 1;
    for (int i = 0; i < MP; i++) begin
      active[i] = 1'b0; done[i] = 1'b0; gap[i] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < MP; i++) begin
        if (done[i]) begin
          done[i]   = 1'b0;
          active[i] = 1'b0;
          gap[i]    = int'($urandom_range(0, 3));
          drive(i, r_addr[i], r_wr[i], r_wdata[i], 1'b0);
        end else if (!active[i]) begin
          if (gap[i] > 0) gap[i]--;
          else if ($urandom_range(0, 1) == 1) begin
            active[i]  = 1'b1;
            r_addr[i]  = {4'h0, 4'($urandom_range(0, 6)), 8'($urandom)};
            r_wr[i]    = 1'($urandom);
            r_wdata[i] = 16'($urandom);
            drive(i, r_addr[i], r_wr[i], r_wdata[i], 1'b1);
          end
        end
      end
      if (m_busy && n > m_start)
        drive(m_cur, 16'($urandom), ~m_wr, 16'($urandom), 1'b1);
      @(negedge clk);
      model_step(n);
    end
    tick();
    drop_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
